// File: rtl/adc0808_scan_scheduler_pkg.sv
// Shared types and default timing for the ADC0808 scan scheduler.
// The default constants assume a 100 MHz clock.
package adc0808_scan_scheduler_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEF_ALE_SETUP_CYC = 2;
  localparam int unsigned DEF_PULSE_CYC     = 25;
  localparam int unsigned DEF_EOC_FALL_TO   = 4000;
  localparam int unsigned DEF_EOC_RISE_TO   = 200000;
  localparam int unsigned DEF_OE_SETTLE_CYC = 10;
  localparam int unsigned DEF_SCAN_GAP_CYC  = 100;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR    = 4'd1,
    ST_ALE     = 4'd2,
    ST_START   = 4'd3,
    ST_WAIT_LO = 4'd4,
    ST_WAIT_HI = 4'd5,
    ST_READ    = 4'd6,
    ST_DONE    = 4'd7,
    ST_GAP     = 4'd8
  } state_e;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc0808_scan_scheduler_if.sv
// Bundles the host request, ADC pin and result signals of the scan scheduler.
// master = scheduler side, slave = host/ADC/testbench side.
interface adc0808_scan_scheduler_if
  import adc0808_scan_scheduler_pkg::*;
;
  logic              enable;
  logic [NUM_CH-1:0] chan_mask;
  logic              req_valid;
  logic [CH_W-1:0]   req_chan;
  logic              req_ready;
  logic              adc_eoc;
  logic [DATA_W-1:0] adc_data;
  logic              adc_ale;
  logic              adc_start;
  logic              adc_oe;
  logic [CH_W-1:0]   adc_addr;
  logic              res_valid;
  logic [CH_W-1:0]   res_chan;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
  logic              res_host;
  logic              busy;

  modport master (
    input  enable, chan_mask, req_valid, req_chan, adc_eoc, adc_data,
    output req_ready, adc_ale, adc_start, adc_oe, adc_addr,
           res_valid, res_chan, res_data, res_timeout, res_host, busy
  );

  modport slave (
    output enable, chan_mask, req_valid, req_chan, adc_eoc, adc_data,
    input  req_ready, adc_ale, adc_start, adc_oe, adc_addr,
           res_valid, res_chan, res_data, res_timeout, res_host, busy
  );

endinterface

// File: rtl/adc0808_scan_scheduler_picker.sv
// Round-robin channel picker: first set mask bit strictly after the pointer,
// wrapping, with the pointer's own channel considered last.
module adc0808_scan_scheduler_picker
  import adc0808_scan_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_ptr,
  output logic              o_found,
  output logic [CH_W-1:0]   o_chan
);

  // Walk from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    o_found = |i_mask;
    o_chan  = i_ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (i_mask[CH_W'(i_ptr + CH_W'(i))]) begin
        o_chan = CH_W'(i_ptr + CH_W'(i));
      end
    end
  end

endmodule

// File: rtl/adc0808_scan_scheduler.sv
// Drives the ADC0808 control pins and runs each conversion, arbitrating between
// a background round-robin scan and latched one-shot host requests.
module adc0808_scan_scheduler
  import adc0808_scan_scheduler_pkg::*;
#(
  parameter int unsigned ALE_SETUP_CYC = DEF_ALE_SETUP_CYC,
  parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
  parameter int unsigned EOC_FALL_TO   = DEF_EOC_FALL_TO,
  parameter int unsigned EOC_RISE_TO   = DEF_EOC_RISE_TO,
  parameter int unsigned OE_SETTLE_CYC = DEF_OE_SETTLE_CYC,
  parameter int unsigned SCAN_GAP_CYC  = DEF_SCAN_GAP_CYC
) (
  input logic                       i_clk,
  input logic                       i_reset_n,
  adc0808_scan_scheduler_if.master  io_bus
);

  localparam int unsigned CNT_MAX = max_u(max_u(max_u(ALE_SETUP_CYC, PULSE_CYC),
                                                max_u(EOC_FALL_TO, EOC_RISE_TO)),
                                          max_u(OE_SETTLE_CYC, SCAN_GAP_CYC));
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
  localparam cnt_t T_SETUP = cnt_t'(ALE_SETUP_CYC - 1);
  localparam cnt_t T_PULSE = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t T_FALL  = cnt_t'(EOC_FALL_TO - 1);
  localparam cnt_t T_RISE  = cnt_t'(EOC_RISE_TO - 1);
  localparam cnt_t T_OE    = cnt_t'(OE_SETTLE_CYC - 1);
  // The IDLE selection cycle counts as the last idle cycle of the gap.
  localparam cnt_t T_GAP   = cnt_t'((SCAN_GAP_CYC > 1) ? SCAN_GAP_CYC - 1 : 1);

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == CNT_SAT) ? c : c + cnt_t'(1);
  endfunction

  state_e              r_state;
  cnt_t                r_cnt;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_addr;
  logic                r_host;
  logic                r_req_pend;
  logic [CH_W-1:0]     r_req_chan;
  logic                r_eoc_s1;
  logic                r_eoc_s2;
  logic                r_ale;
  logic                r_start;
  logic                r_oe;
  logic                r_res_valid;
  logic [CH_W-1:0]     r_res_chan;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_timeout;
  logic                r_res_host;

  logic                w_found;
  logic [CH_W-1:0]     w_next_chan;

  adc0808_scan_scheduler_picker u_picker (
    .i_mask  (io_bus.chan_mask),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_chan  (w_next_chan)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ptr         <= CH_W'(NUM_CH - 1);
      r_addr        <= '0;
      r_host        <= 1'b0;
      r_req_pend    <= 1'b0;
      r_req_chan    <= '0;
      r_eoc_s1      <= 1'b0;
      r_eoc_s2      <= 1'b0;
      r_ale         <= 1'b0;
      r_start       <= 1'b0;
      r_oe          <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_chan    <= '0;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
      r_res_host    <= 1'b0;
    end else begin
      r_eoc_s1 <= io_bus.adc_eoc;
      r_eoc_s2 <= r_eoc_s1;
      r_cnt    <= sat_inc(r_cnt);

      if (io_bus.req_valid && !r_req_pend) begin
        r_req_pend <= 1'b1;
        r_req_chan <= io_bus.req_chan;
      end

      case (r_state)
        ST_IDLE: begin
          // A request latched this same cycle is not yet visible: scan goes first.
          if (r_req_pend) begin
            r_addr  <= r_req_chan;
            r_host  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_ADDR;
          end else if (io_bus.enable && w_found) begin
            r_addr  <= w_next_chan;
            r_ptr   <= w_next_chan;
            r_host  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (r_cnt >= T_SETUP) begin
            r_ale   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_ALE;
          end
        end
        ST_ALE: begin
          if (r_cnt >= T_PULSE) begin
            r_ale   <= 1'b0;
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt >= T_PULSE) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!r_eoc_s2) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_HI;
          end else if (r_cnt >= T_FALL) begin
            r_res_valid   <= 1'b1;
            r_res_chan    <= r_addr;
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_host    <= r_host;
            r_state       <= ST_DONE;
          end
        end
        ST_WAIT_HI: begin
          if (r_eoc_s2) begin
            r_oe    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_READ;
          end else if (r_cnt >= T_RISE) begin
            r_res_valid   <= 1'b1;
            r_res_chan    <= r_addr;
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_host    <= r_host;
            r_state       <= ST_DONE;
          end
        end
        ST_READ: begin
          if (r_cnt >= T_OE) begin
            r_oe          <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_chan    <= r_addr;
            r_res_data    <= io_bus.adc_data;
            r_res_timeout <= 1'b0;
            r_res_host    <= r_host;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_res_valid <= 1'b0;
          if (r_host) begin
            r_req_pend <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt   <= cnt_t'(1);
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_req_pend || (r_cnt >= T_GAP)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready   = ~r_req_pend;
  assign io_bus.adc_ale     = r_ale;
  assign io_bus.adc_start   = r_start;
  assign io_bus.adc_oe      = r_oe;
  assign io_bus.adc_addr    = r_addr;
  assign io_bus.res_valid   = r_res_valid;
  assign io_bus.res_chan    = r_res_chan;
  assign io_bus.res_data    = r_res_data;
  assign io_bus.res_timeout = r_res_timeout;
  assign io_bus.res_host    = r_res_host;
  assign io_bus.busy        = (r_state != ST_IDLE) && (r_state != ST_GAP);

endmodule
